// File: rtl/start_for_srl_fifo_ctrl.sv
// start_for_srl_fifo_ctrl
//   Shallow SRL-style FIFO (controller plus storage) used for start tokens and
//   small data between dataflow processes. New words shift in at entry 0; the
//   oldest word sits at entry cnt-1 and is presented first-word-fall-through.
//
// Ports
//   clk               rising-edge clock
//   ap_rst_n          asynchronous active-low reset
//   if_full_n         high when a word can be accepted
//   if_write_ce       producer clock-enable qualifier
//   if_write          producer write request
//   if_din            write data
//   if_empty_n        high when if_dout holds a valid word
//   if_read_ce        consumer clock-enable qualifier
//   if_read           consumer pop request
//   if_dout           oldest stored word (combinational from storage)
//   if_num_data_valid current occupancy
module start_for_srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 6
) (
  input  logic                  clk,
  input  logic                  ap_rst_n,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_LAST = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] srl_sig [DEPTH];
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  full_n;
  logic                  empty_n;
  logic                  wr;
  logic                  rd;

  assign wr = if_write & if_write_ce & full_n;
  assign rd = if_read  & if_read_ce  & empty_n;

  // Storage is not reset; it shifts only on an accepted write.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--) begin
        srl_sig[i] <= srl_sig[i-1];
      end
      srl_sig[0] <= if_din;
    end
  end

  // addr is kept registered next to cnt as cnt-1 (0 when empty), so the read
  // mux never sees a wrapped subtract. On wr & rd both hold: the shift alone
  // moves the second-oldest word into the read slot.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt     <= '0;
      addr    <= '0;
      empty_n <= 1'b0;
      full_n  <= 1'b1;
    end else if (wr && !rd) begin
      cnt     <= cnt + CNT_ONE;
      addr    <= (cnt == '0) ? '0 : addr + ADDR_ONE;
      empty_n <= 1'b1;
      full_n  <= (cnt != CNT_LAST);
    end else if (rd && !wr) begin
      cnt     <= cnt - CNT_ONE;
      addr    <= (cnt == CNT_ONE) ? '0 : addr - ADDR_ONE;
      full_n  <= 1'b1;
      empty_n <= (cnt != CNT_ONE);
    end
  end

  assign if_dout           = srl_sig[addr];
  assign if_full_n         = full_n;
  assign if_empty_n        = empty_n;
  assign if_num_data_valid = cnt;

endmodule

// File: tb/tb_start_for_srl_fifo_ctrl.sv
// Testbench for start_for_srl_fifo_ctrl: directed vector table on a 6-deep
// 8-bit instance, hand-written async-reset sequence, then randomized traffic
// on both the 6-deep and a 1-deep instance checked against queue models.
module tb_start_for_srl_fifo_ctrl;

  logic       clk;
  logic       ap_rst_n;

  // 6-deep instance
  logic       full_n, empty_n;
  logic       write_ce, write, read_ce, read;
  logic [7:0] din, dout;
  logic [3:0] count;

  // 1-deep instance
  logic       full_n1, empty_n1;
  logic       write_ce1, write1, read_ce1, read1;
  logic [7:0] din1, dout1;
  logic [1:0] count1;

  int total_checks;
  int passed_checks;

  start_for_srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(6)) dut (
    .clk(clk), .ap_rst_n(ap_rst_n),
    .if_full_n(full_n), .if_write_ce(write_ce), .if_write(write), .if_din(din),
    .if_empty_n(empty_n), .if_read_ce(read_ce), .if_read(read), .if_dout(dout),
    .if_num_data_valid(count)
  );

  start_for_srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .ap_rst_n(ap_rst_n),
    .if_full_n(full_n1), .if_write_ce(write_ce1), .if_write(write1), .if_din(din1),
    .if_empty_n(empty_n1), .if_read_ce(read_ce1), .if_read(read1), .if_dout(dout1),
    .if_num_data_valid(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w, wce;
    logic [7:0] d;
    logic       r, rce;
    logic       full_n, empty_n;
    logic [3:0] cnt;
    logic       chk_dout;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[40];
  int   ntbl;

  function automatic vec_t mk(logic w, logic wce, logic [7:0] d, logic r, logic rce,
                              logic fn, logic en, logic [3:0] c, logic cd, logic [7:0] o);
    vec_t v;
    v.w = w; v.wce = wce; v.d = d; v.r = r; v.rce = rce;
    v.full_n = fn; v.empty_n = en; v.cnt = c; v.chk_dout = cd; v.dout = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive6(input logic w, input logic wce, input logic [7:0] d,
                        input logic r, input logic rce);
    write = w; write_ce = wce; din = d; read = r; read_ce = rce;
  endtask

  logic [7:0] q6[$];
  logic [7:0] q1[$];

  initial begin
    total_checks = 0;
    passed_checks = 0;
    ap_rst_n = 1'b0;
    drive6(0, 0, 8'h00, 0, 0);
    write1 = 0; write_ce1 = 0; din1 = 0; read1 = 0; read_ce1 = 0;

    // directed table: expectations are after the clock edge that applies the inputs
    ntbl = 0;
    tbl[ntbl++] = mk(0,0,8'd0, 1,1, 1,0,4'd0, 0,8'd0);   // read while empty ignored
    for (int i = 1; i <= 6; i++)
      tbl[ntbl++] = mk(1,1,8'(i), 0,0, (i < 6),1,4'(i), 1,8'd1);
    tbl[ntbl++] = mk(1,1,8'd7, 0,0, 0,1,4'd6, 1,8'd1);   // write while full ignored
    for (int j = 1; j <= 6; j++)
      tbl[ntbl++] = mk(0,0,8'd0, 1,1, 1,(j < 6),4'(6-j), (j < 6),8'(j+1));
    tbl[ntbl++] = mk(1,1,8'd10, 0,0, 1,1,4'd1, 1,8'd10); // A
    tbl[ntbl++] = mk(1,1,8'd11, 0,0, 1,1,4'd2, 1,8'd10); // B
    tbl[ntbl++] = mk(1,1,8'd12, 0,0, 1,1,4'd3, 1,8'd10); // C
    tbl[ntbl++] = mk(1,0,8'd99, 0,0, 1,1,4'd3, 1,8'd10); // write ce low: no shift
    tbl[ntbl++] = mk(0,0,8'd0, 1,0, 1,1,4'd3, 1,8'd10);  // read ce low: no pop
    tbl[ntbl++] = mk(1,1,8'd13, 1,1, 1,1,4'd3, 1,8'd11); // simultaneous pops A
    tbl[ntbl++] = mk(1,1,8'd13, 1,1, 1,1,4'd3, 1,8'd12); // pops B
    tbl[ntbl++] = mk(1,1,8'd13, 1,1, 1,1,4'd3, 1,8'd13); // pops C
    tbl[ntbl++] = mk(0,0,8'd0, 1,1, 1,1,4'd2, 1,8'd13);  // pops D
    tbl[ntbl++] = mk(0,0,8'd0, 1,1, 1,1,4'd1, 1,8'd13);
    tbl[ntbl++] = mk(0,0,8'd0, 1,1, 1,0,4'd0, 0,8'd0);

    // reset held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full_n", 32'(full_n), 32'd1);
    chk("rst_empty_n", 32'(empty_n), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst1_full_n", 32'(full_n1), 32'd1);
    chk("rst1_empty_n", 32'(empty_n1), 32'd0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < ntbl; k++) begin
      drive6(tbl[k].w, tbl[k].wce, tbl[k].d, tbl[k].r, tbl[k].rce);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_full_n", k), 32'(full_n), 32'(tbl[k].full_n));
      chk($sformatf("vec%0d_empty_n", k), 32'(empty_n), 32'(tbl[k].empty_n));
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(tbl[k].cnt));
      if (tbl[k].chk_dout) chk($sformatf("vec%0d_dout", k), 32'(dout), 32'(tbl[k].dout));
    end

    // async reset mid-operation with 4 words stored
    for (int i = 0; i < 4; i++) begin
      drive6(1, 1, 8'(20 + i), 0, 0);
      @(posedge clk);
      #1;
    end
    drive6(0, 0, 8'd0, 0, 0);
    chk("pre_arst_count", 32'(count), 32'd4);
    chk("pre_arst_dout", 32'(dout), 32'd20);
    @(posedge clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_full_n", 32'(full_n), 32'd1);
    chk("arst_empty_n", 32'(empty_n), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    drive6(1, 1, 8'd9, 0, 0);
    @(posedge clk);
    #1;
    drive6(0, 0, 8'd0, 0, 0);
    chk("post_arst_count", 32'(count), 32'd1);
    chk("post_arst_empty_n", 32'(empty_n), 32'd1);
    chk("post_arst_dout", 32'(dout), 32'd9);

    // clean start for randomized traffic
    @(negedge clk);
    ap_rst_n = 1'b0;
    @(negedge clk);
    ap_rst_n = 1'b1;
    q6.delete();
    q1.delete();

    for (int c = 0; c < 600; c++) begin
      int unsigned wp;
      logic w6, wc6, r6, rc6, w1, wc1, r1, rc1;
      logic [7:0] d6, d1;
      bit acc_w6, acc_r6, acc_w1, acc_r1;
      wp = ((c / 60) % 2 == 0) ? 75 : 25;
      w6 = ($urandom_range(0, 99) < wp); wc6 = ($urandom_range(0, 9) != 0);
      r6 = ($urandom_range(0, 99) < 100 - wp); rc6 = ($urandom_range(0, 9) != 0);
      d6 = 8'($urandom);
      w1 = $urandom_range(0, 1) == 1; wc1 = $urandom_range(0, 3) != 0;
      r1 = $urandom_range(0, 1) == 1; rc1 = $urandom_range(0, 3) != 0;
      d1 = 8'($urandom);
      drive6(w6, wc6, d6, r6, rc6);
      write1 = w1; write_ce1 = wc1; din1 = d1; read1 = r1; read_ce1 = rc1;

      acc_w6 = w6 && wc6 && (q6.size() < 6);
      acc_r6 = r6 && rc6 && (q6.size() > 0);
      acc_w1 = w1 && wc1 && (q1.size() < 1);
      acc_r1 = r1 && rc1 && (q1.size() > 0);
      @(posedge clk);
      #1;
      if (acc_r6) void'(q6.pop_front());
      if (acc_w6) q6.push_back(d6);
      if (acc_r1) void'(q1.pop_front());
      if (acc_w1) q1.push_back(d1);

      chk("rnd6_count", 32'(count), 32'(q6.size()));
      chk("rnd6_full_n", 32'(full_n), 32'(q6.size() < 6));
      chk("rnd6_empty_n", 32'(empty_n), 32'(q6.size() > 0));
      if (q6.size() > 0) chk("rnd6_dout", 32'(dout), 32'(q6[0]));
      chk("rnd1_count", 32'(count1), 32'(q1.size()));
      chk("rnd1_full_n", 32'(full_n1), 32'(q1.size() < 1));
      chk("rnd1_empty_n", 32'(empty_n1), 32'(q1.size() > 0));
      if (q1.size() > 0) chk("rnd1_dout", 32'(dout1), 32'(q1[0]));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
